mips_mc_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback steps, one step per clock, for the opcode/function set shared by the single-cycle, multicycle and pipelined designs.
- Drives every datapath mux select and write enable, and decodes function codes to ALU control.
- Sits beside the datapath; the instruction register fields and ALU flags feed back in.

---
 rtl/mips_mc_control.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Latency: one step per clock; outputs combinational from state (BRANCH pcen also from zero/a_sign).
// Backpressure: none; reset_n low aborts the instruction in flight and masks every enable at once.
module mips_mc_control #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       zero,
    input  logic       a_sign,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immext,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic       instr_done
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_REGIMM = 6'd1;   // BLTZ (rt=0) / BGEZ (rt=1)
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_ADDI   = 6'd8;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    // R-type function codes
    localparam logic [5:0] F_JR  = 6'd8;
    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_XOR = 6'd38;
    localparam logic [5:0] F_NOR = 6'd39;
    localparam logic [5:0] F_SLT = 6'd42;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Branch flavour remembered from DECODE so BRANCH never looks at the IR
    localparam logic [1:0] BR_EQ  = 2'd0;
    localparam logic [1:0] BR_NE  = 2'd1;
    localparam logic [1:0] BR_LTZ = 2'd2;
    localparam logic [1:0] BR_GEZ = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ORIEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12,
        S_JAL     = 4'd13,
        S_JR      = 4'd14,
        S_BAD     = 4'd15
    } state_t;

    // The link register number is hardwired in the datapath behind regdst=2'b10;
    // it is kept here only so the controller documents which register JAL targets.
    logic [4:0] ra_reg_unused;
    assign ra_reg_unused = RA_REG;

    state_t     state_q, state_d;
    logic [1:0] br_kind_q, br_kind_d;
    logic [2:0] alu_op_q, alu_op_d;

    state_t     dec_next;
    logic       dec_illegal;
    logic [1:0] dec_br;
    logic [2:0] dec_alu;

    // State register plus the decode facts captured for later steps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            br_kind_q <= BR_EQ;
            alu_op_q  <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            br_kind_q <= br_kind_d;
            alu_op_q  <= alu_op_d;
        end
    end

    // Instruction decode: dispatch target, legality, branch flavour and R-type ALU op
    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        dec_br      = BR_EQ;
        dec_alu     = ALU_ADD;
        case (opcode)
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_RTYPE: begin
                dec_next = S_EXECUTE;
                case (funct)
                    F_JR:    dec_next = S_JR;
                    F_ADD:   dec_alu  = ALU_ADD;
                    F_SUB:   dec_alu  = ALU_SUB;
                    F_AND:   dec_alu  = ALU_AND;
                    F_OR:    dec_alu  = ALU_OR;
                    F_XOR:   dec_alu  = ALU_XOR;
                    F_NOR:   dec_alu  = ALU_NOR;
                    F_SLT:   dec_alu  = ALU_SLT;
                    default: begin
                        dec_next    = S_FETCH;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            OP_BEQ: begin
                dec_next = S_BRANCH;
                dec_br   = BR_EQ;
            end
            OP_BNE: begin
                dec_next = S_BRANCH;
                dec_br   = BR_NE;
            end
            OP_REGIMM: begin
                if (rt == 5'd0) begin
                    dec_next = S_BRANCH;
                    dec_br   = BR_LTZ;
                end else if (rt == 5'd1) begin
                    dec_next = S_BRANCH;
                    dec_br   = BR_GEZ;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_ADDI: dec_next = S_ADDIEX;
            OP_ORI:  dec_next = S_ORIEX;
            OP_J:    dec_next = S_JUMP;
            OP_JAL:  dec_next = S_JAL;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-state logic; the IR is only consulted in DECODE and MEMADR
    always_comb begin
        state_d   = S_FETCH;
        br_kind_d = br_kind_q;
        alu_op_d  = alu_op_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                state_d   = dec_next;
                br_kind_d = dec_br;
                alu_op_d  = dec_alu;
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_IMMWB;
            S_ORIEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;   // final steps and the unused encoding
        endcase
    end

    // Datapath controls per state; enables and pulses are masked while reset is held
    always_comb begin
        pcen       = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immext     = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcen    = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;            // branch target into ALUOut
                illegal = dec_illegal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 2'b01;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = alu_op_q;
            end
            S_ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 2'b01;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
                case (br_kind_q)
                    BR_EQ:   pcen = zero;
                    BR_NE:   pcen = ~zero;
                    BR_LTZ:  pcen = a_sign;
                    default: pcen = ~a_sign;
                endcase
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                immext     = 1'b1;
                alucontrol = ALU_OR;
            end
            S_IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so the link value is ready this cycle
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                regwrite   = 1'b1;
                regdst     = 2'b10;
                memtoreg   = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                pcsrc      = 2'b11;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;                     // unused encoding: everything idle
        endcase
        if (!reset_n) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed plan cases then random instructions vs a per-instruction step model.
// Each instruction is expanded into the list of control words it should produce, one per cycle.
// No flow control on the DUT; inputs change 1ns after a rising edge, outputs sampled on falling edges.
module tb_mips_mc_control;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode, funct;
    logic [4:0] rt;
    logic       zero, a_sign;
    logic       pcen, iord, memwrite, irwrite, regwrite, alusrca, immext, illegal, instr_done;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;

    always #5 clk = ~clk;

    mips_mc_control #(.RA_REG(5'd31)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .rt(rt),
        .zero(zero), .a_sign(a_sign), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .immext(immext), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .instr_done(instr_done)
    );

    typedef struct packed {
        logic       pcen, iord, memwrite, irwrite;
        logic [1:0] regdst, memtoreg;
        logic       regwrite, alusrca;
        logic [1:0] alusrcb;
        logic       immext;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal, instr_done;
    } ctl_t;

    ctl_t dut_ctl;
    assign dut_ctl = '{pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                       alusrcb, immext, pcsrc, alucontrol, illegal, instr_done};

    int   n_checks = 0;
    int   n_errors = 0;
    ctl_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic bit is_rfunct(input logic [5:0] f);
        return f inside {6'd8, 6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42};
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] f, input logic [4:0] r);
        if (op inside {6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd13, 6'd35, 6'd43}) return 1'b1;
        if (op == 6'd0) return is_rfunct(f);
        if (op == 6'd1) return (r == 5'd0) || (r == 5'd1);
        return 1'b0;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'd32:   return 3'b010;
            6'd34:   return 3'b110;
            6'd36:   return 3'b000;
            6'd37:   return 3'b001;
            6'd38:   return 3'b011;
            6'd39:   return 3'b100;
            default: return 3'b111;
        endcase
    endfunction

    // Cycles from FETCH to the last step, by instruction class
    function automatic int lat_of(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'd35:                 return 5;
            6'd43, 6'd8, 6'd13:    return 4;
            6'd0:                  return (f == 6'd8) ? 3 : 4;
            default:               return 3;   // branches, J, JAL
        endcase
    endfunction

    // Expand one instruction into its expected per-cycle control words
    task automatic build(input logic [5:0] op, input logic [5:0] f, input logic [4:0] r,
                         input logic z, input logic s, output bit legal);
        ctl_t c;
        bit   taken;
        exp_q.delete();
        c = idle(); c.irwrite = 1; c.alusrcb = 2'b01; c.pcen = 1; exp_q.push_back(c);
        legal = is_legal(op, f, r);
        c = idle(); c.alusrcb = 2'b11; c.illegal = !legal; exp_q.push_back(c);
        if (!legal) return;
        c = idle();
        if (op == 6'd35 || op == 6'd43) begin
            c.alusrca = 1; c.alusrcb = 2'b10; exp_q.push_back(c);
            c = idle(); c.iord = 1;
            if (op == 6'd43) begin
                c.memwrite = 1; c.instr_done = 1; exp_q.push_back(c);
            end else begin
                exp_q.push_back(c);
                c = idle(); c.regwrite = 1; c.memtoreg = 2'b01; c.instr_done = 1; exp_q.push_back(c);
            end
        end else if (op == 6'd0 && f == 6'd8) begin
            c.pcsrc = 2'b11; c.pcen = 1; c.instr_done = 1; exp_q.push_back(c);
        end else if (op == 6'd0) begin
            c.alusrca = 1; c.alucontrol = alu_of(f); exp_q.push_back(c);
            c = idle(); c.regwrite = 1; c.regdst = 2'b01; c.instr_done = 1; exp_q.push_back(c);
        end else if (op == 6'd4 || op == 6'd5 || op == 6'd1) begin
            if (op == 6'd4)      taken = z;
            else if (op == 6'd5) taken = !z;
            else                 taken = (r == 5'd0) ? s : !s;
            c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = taken;
            c.instr_done = 1; exp_q.push_back(c);
        end else if (op == 6'd8 || op == 6'd13) begin
            c.alusrca = 1; c.alusrcb = 2'b10;
            if (op == 6'd13) begin
                c.immext = 1; c.alucontrol = 3'b001;
            end
            exp_q.push_back(c);
            c = idle(); c.regwrite = 1; c.instr_done = 1; exp_q.push_back(c);
        end else begin
            c.pcsrc = 2'b10; c.pcen = 1; c.instr_done = 1;
            if (op == 6'd3) begin
                c.regwrite = 1; c.regdst = 2'b10; c.memtoreg = 2'b10;
            end
            exp_q.push_back(c);
        end
    endtask

    // Present one instruction starting in its FETCH cycle and check every step
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] f,
                             input logic [4:0] r, input logic z, input logic s);
        bit legal;
        int done_at;
        opcode = op; funct = f; rt = r; zero = z; a_sign = s;
        build(op, f, r, z, s, legal);
        done_at = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            chk($sformatf("%s op%0d f%0d step%0d", name, op, f, i), 32'(dut_ctl), 32'(exp_q[i]));
            if (instr_done === 1'b1 && done_at == 0) done_at = i + 1;
            @(posedge clk);
            #1;
        end
        if (legal) chk($sformatf("%s op%0d latency", name, op), done_at, lat_of(op, f));
    endtask

    initial begin
        logic [5:0] op_tab [12];
        logic [5:0] fn_tab [9];
        logic [5:0] op, f;
        logic [4:0] r;

        reset_n = 1'b0; opcode = 6'd35; funct = 6'd0; rt = 5'd0; zero = 1'b0; a_sign = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset enables", {26'b0, pcen, irwrite, memwrite, regwrite, illegal, instr_done}, 32'd0);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed cases from the plan
        run_instr("lw",    6'd35, 6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("slt",   6'd0,  6'd42, 5'd0, 1'b0, 1'b0);
        run_instr("nor",   6'd0,  6'd39, 5'd0, 1'b0, 1'b0);
        run_instr("beq",   6'd4,  6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("beq_t", 6'd4,  6'd0,  5'd0, 1'b1, 1'b0);
        run_instr("bne",   6'd5,  6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("bltz",  6'd1,  6'd0,  5'd0, 1'b0, 1'b1);
        run_instr("bgez",  6'd1,  6'd0,  5'd1, 1'b0, 1'b1);
        run_instr("jal",   6'd3,  6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("jr",    6'd0,  6'd8,  5'd0, 1'b0, 1'b0);
        run_instr("bad63", 6'd63, 6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("badrt", 6'd1,  6'd0,  5'd2, 1'b0, 1'b0);
        run_instr("badfn", 6'd0,  6'd1,  5'd0, 1'b0, 1'b0);
        run_instr("sw",    6'd43, 6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("addi",  6'd8,  6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("ori",   6'd13, 6'd0,  5'd0, 1'b0, 1'b0);
        run_instr("j",     6'd2,  6'd0,  5'd0, 1'b0, 1'b0);

        // Reset dropped during the store's write cycle
        opcode = 6'd43; funct = 6'd0; rt = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sw memwr memwrite", 32'(memwrite), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst abort enables", {28'b0, memwrite, regwrite, pcen, irwrite}, 32'd0);
        chk("rst abort fetch", 32'(alusrcb), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_instr("post_rst", 6'd35, 6'd0, 5'd0, 1'b0, 1'b0);

        // Random instruction stream
        op_tab = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd13, 6'd35, 6'd43, 6'd0, 6'd63};
        fn_tab = '{6'd8, 6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0};
        for (int n = 0; n < 400; n++) begin
            op = op_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            f = fn_tab[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) f = 6'($urandom);
            r = 5'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) r = 5'($urandom);
            run_instr("rnd", op, f, r, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
